// File: rtl/sccb_pkg.sv
// ============================================================================
// Module  : sccb_pkg
// Brief   : Shared SCCB state encoding, default device ID and ACK/NA levels.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ID        = 4'd1,
    ST_ID_ACK    = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } sccb_state_e;

  localparam logic [6:0] SCCB_DEVICE_ID = 7'h21;
  localparam logic       SCCB_ACK       = 1'b0;
  localparam logic       SCCB_NA        = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sccb_line_sync.sv
// ============================================================================
// Module  : sccb_line_sync
// Brief   : Synchronises SCL/SDA into clk and derives edge/start/stop strobes.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sccb_line_sync (
  input  logic clk,
  input  logic rstn,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic scl_meta_d, scl_sync_d, scl_prev_d;
  logic sda_meta_d, sda_sync_d, sda_prev_d;

  always_comb begin
    scl_meta_d = scl;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = sda_in;
    sda_sync_d = sda_meta_q;
    sda_prev_d = sda_sync_q;
  end

  // Flops reset high so the idle bus never produces a spurious strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_s    = sda_sync_q;
  assign scl_rise = scl_sync_q & ~scl_prev_q;
  assign scl_fall = ~scl_sync_q & scl_prev_q;
  assign start    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

endmodule

`default_nettype wire

// File: rtl/sccb_slave.sv
// ============================================================================
// Module  : sccb_slave
// Brief   : SCCB responder with ID match, 3-phase write, 2-phase read, regfile.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sccb_slave
  import sccb_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [6:0] DEVICE_ID  = SCCB_DEVICE_ID
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic [DATA_WIDTH-1:0] host_data,
  output logic                  reg_wr_en,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(DATA_WIDTH + 1);
  localparam int BW    = $clog2(DATA_WIDTH);

  logic sda_s, scl_rise, scl_fall, start, stop;

  sccb_line_sync u_line_sync (
    .clk      (clk),
    .rstn     (rstn),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  sccb_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] sub_addr_q, sub_addr_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];

  logic [DATA_WIDTH-1:0] shift_in;
  logic [DATA_WIDTH-1:0] rd_byte;
  logic [BW-1:0]         bit_idx;

  assign shift_in = {shift_q[DATA_WIDTH-2:0], sda_s};
  assign rd_byte  = regs_q[sub_addr_q];
  assign bit_idx  = BW'(DATA_WIDTH - 1) - cnt_q[BW-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sub_addr_d = sub_addr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (stop) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d  = ST_ID;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ST_ID, ST_SUB, ST_WDATA: begin
          if (scl_rise && cnt_q != CW'(DATA_WIDTH)) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 1'b1;
            // The write commits on the last data rise, before the ACK bit.
            if (state_q == ST_WDATA && cnt_q == CW'(DATA_WIDTH - 1)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = sub_addr_q;
              wr_data_d = shift_in;
            end
          end else if (scl_fall && cnt_q == CW'(DATA_WIDTH)) begin
            cnt_d = '0;
            if (state_q == ST_ID) begin
              if (shift_q[DATA_WIDTH-1:1] == DEVICE_ID) begin
                state_d  = ST_ID_ACK;
                sda_oe_d = 1'b1;
              end else begin
                state_d  = ST_WAIT_STOP;
              end
            end else if (state_q == ST_SUB) begin
              sub_addr_d = ADDR_WIDTH'(shift_q);
              state_d    = ST_SUB_ACK;
              sda_oe_d   = 1'b1;
            end else begin
              state_d  = ST_WDATA_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end

        ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
          if (scl_rise) begin
            cnt_d = CW'(1);
          end else if (scl_fall && cnt_q == CW'(1)) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            if (state_q == ST_ID_ACK) begin
              if (shift_q[0]) begin
                state_d  = ST_RDATA;
                sda_oe_d = ~rd_byte[DATA_WIDTH-1];
              end else begin
                state_d  = ST_SUB;
              end
            end else if (state_q == ST_SUB_ACK) begin
              state_d = ST_WDATA;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise && cnt_q != CW'(DATA_WIDTH)) begin
            cnt_d = cnt_q + 1'b1;
          end else if (scl_fall) begin
            if (cnt_q == CW'(DATA_WIDTH)) begin
              state_d  = ST_RDATA_ACK;
              cnt_d    = '0;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~rd_byte[bit_idx];
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == SCCB_NA) begin
              state_d = ST_WAIT_STOP;
            end else begin
              // Next fall with cnt 0 loads the MSB of the following byte.
              sub_addr_d = sub_addr_q + 1'b1;
              state_d    = ST_RDATA;
              cnt_d      = '0;
            end
          end
        end

        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      sub_addr_q <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sub_addr_q <= sub_addr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en_d) begin
      regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign host_data   = regs_q[host_addr];

endmodule

`default_nettype wire

// File: tb/tb_sccb_slave.sv
// ============================================================================
// Module  : tb_sccb_slave
// Brief   : Bit-banged SCCB master driving sccb_slave, with write/read scoreboards.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sccb_slave;

  localparam int Q = 3;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] host_addr = 8'h00;
  logic [7:0] host_data;
  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       busy;

  assign sda_line = m_sda & ~sda_oe;

  sccb_slave dut (
    .clk         (clk),
    .rstn        (rstn),
    .scl         (scl),
    .sda_in      (sda_line),
    .sda_oe      (sda_oe),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         wr_pulses = 0;
  logic       wr_en_prev = 1'b0;
  logic       oe_seen = 1'b0;
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wvec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard: every reg_wr_en pulse must match the oldest queued write.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (sda_oe) oe_seen = 1'b1;
    if (rstn && reg_wr_en) begin
      chk("wr_en_single_cycle", {31'd0, wr_en_prev}, 32'd0);
      if (!wr_en_prev) wr_pulses++;
      if (wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_wr: addr %0h data %0h with none expected", reg_wr_addr, reg_wr_data);
      end else begin
        exp = wr_q.pop_front();
        chk("wr_addr", {24'd0, reg_wr_addr}, {24'd0, exp[15:8]});
        chk("wr_data", {24'd0, reg_wr_data}, {24'd0, exp[7:0]});
      end
    end
    wr_en_prev = reg_wr_en;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    m_sda = 1'b1; cyc(Q);
    scl = 1'b1;   cyc(H);
    m_sda = 1'b0; cyc(H);
    scl = 1'b0;
  endtask

  task automatic stop_c();
    cyc(Q); m_sda = 1'b0;
    cyc(Q); scl = 1'b1;
    cyc(H); m_sda = 1'b1;
    cyc(H);
  endtask

  task automatic send_bit(input logic b);
    cyc(Q); m_sda = b;
    cyc(Q); scl = 1'b1;
    cyc(H); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    cyc(Q); m_sda = 1'b1;
    cyc(Q); scl = 1'b1;
    cyc(3); ack = ~sda_line;
    cyc(3); scl = 1'b0;
  endtask

  task automatic read_byte(input logic nack, input string name);
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 7; i >= 0; i--) begin
      cyc(Q); m_sda = 1'b1;
      cyc(Q); scl = 1'b1;
      cyc(3); d[i] = sda_line;
      cyc(3); scl = 1'b0;
    end
    if (rd_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: read %0h with no expected byte queued", name, d);
    end else begin
      exp = rd_q.pop_front();
      chk(name, {24'd0, d}, {24'd0, exp});
    end
    cyc(Q); m_sda = nack;
    cyc(Q); scl = 1'b1;
    cyc(3); chk("rd_release_9th", {31'd0, sda_oe}, 32'd0);
    cyc(3); scl = 1'b0;
  endtask

  task automatic write3(input logic [7:0] addr, input logic [7:0] data);
    logic a;
    start_c();
    write_byte(8'h42, a); chk("w3_id_ack", {31'd0, a}, 32'd1);
    chk("w3_busy_mid", {31'd0, busy}, 32'd1);
    write_byte(addr, a);  chk("w3_sub_ack", {31'd0, a}, 32'd1);
    wr_q.push_back({addr, data});
    write_byte(data, a);  chk("w3_data_ack", {31'd0, a}, 32'd1);
    stop_c();
    chk("w3_busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic set_sub(input logic [7:0] addr);
    logic a;
    start_c();
    write_byte(8'h42, a); chk("s2_id_ack", {31'd0, a}, 32'd1);
    write_byte(addr, a);  chk("s2_sub_ack", {31'd0, a}, 32'd1);
    stop_c();
  endtask

  initial begin
    wvec_t wv [4];
    logic  a;

    wv[0] = '{addr: 8'hA6, data: 8'h5B};
    wv[1] = '{addr: 8'hFF, data: 8'h95};
    wv[2] = '{addr: 8'h00, data: 8'h73};
    wv[3] = '{addr: 8'h10, data: 8'hC3};

    host_addr = 8'hA6;
    cyc(3);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    chk("rst_wr_addr", {24'd0, reg_wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, reg_wr_data}, 32'd0);
    chk("rst_host_data", {24'd0, host_data}, 32'd0);
    rstn = 1'b1;
    cyc(5);

    // 3-phase writes, then local readback of each register
    for (int i = 0; i < 4; i++) write3(wv[i].addr, wv[i].data);
    for (int i = 0; i < 4; i++) begin
      host_addr = wv[i].addr;
      cyc(1);
      chk("host_readback", {24'd0, host_data}, {24'd0, wv[i].data});
    end

    // 2-phase write of sub-address then 2-phase read with NA
    set_sub(8'hA6);
    rd_q.push_back(8'h5B);
    start_c();
    write_byte(8'h43, a); chk("rd_id_ack", {31'd0, a}, 32'd1);
    read_byte(1'b1, "rd_a6");
    chk("rd_busy_before_stop", {31'd0, busy}, 32'd1);
    stop_c();
    chk("rd_busy_after_stop", {31'd0, busy}, 32'd0);

    // Wrong device ID: never acknowledged, never written
    oe_seen = 1'b0;
    start_c();
    write_byte(8'h60, a); chk("bad_id_nack", {31'd0, a}, 32'd0);
    write_byte(8'hA6, a); chk("bad_id_b1_nack", {31'd0, a}, 32'd0);
    write_byte(8'h11, a); chk("bad_id_b2_nack", {31'd0, a}, 32'd0);
    stop_c();
    chk("bad_id_oe_quiet", {31'd0, oe_seen}, 32'd0);
    chk("bad_id_busy", {31'd0, busy}, 32'd0);

    // Sequential read across the top of the register file
    set_sub(8'hFF);
    rd_q.push_back(8'h95);
    rd_q.push_back(8'h73);
    start_c();
    write_byte(8'h43, a); chk("wrap_id_ack", {31'd0, a}, 32'd1);
    read_byte(1'b0, "rd_ff");
    read_byte(1'b1, "rd_wrap_00");
    stop_c();
    rd_q.push_back(8'h73);
    start_c();
    write_byte(8'h43, a); chk("wrap2_id_ack", {31'd0, a}, 32'd1);
    read_byte(1'b1, "rd_sub_after_wrap");
    stop_c();

    // Repeated start inside a data byte aborts that byte
    start_c();
    write_byte(8'h42, a); chk("rs_id_ack", {31'd0, a}, 32'd1);
    write_byte(8'hA6, a); chk("rs_sub_ack", {31'd0, a}, 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    start_c();
    write_byte(8'h42, a); chk("rs2_id_ack", {31'd0, a}, 32'd1);
    write_byte(8'h95, a); chk("rs2_sub_ack", {31'd0, a}, 32'd1);
    wr_q.push_back({8'h95, 8'h73});
    write_byte(8'h73, a); chk("rs2_data_ack", {31'd0, a}, 32'd1);
    stop_c();
    host_addr = 8'h95; cyc(1);
    chk("rs_written", {24'd0, host_data}, 32'h73);
    host_addr = 8'hA6; cyc(1);
    chk("rs_aborted_untouched", {24'd0, host_data}, 32'h5B);

    // Reset asserted while the slave is driving read data
    set_sub(8'hA6);
    start_c();
    write_byte(8'h43, a); chk("rst_rd_id_ack", {31'd0, a}, 32'd1);
    cyc(Q + 3);
    chk("rst_rd_drive_msb", {31'd0, sda_oe}, 32'd1);
    #2 rstn = 1'b0;
    #1 chk("rst_async_release", {31'd0, sda_oe}, 32'd0);
    scl = 1'b1; m_sda = 1'b1;
    cyc(4);
    rstn = 1'b1;
    cyc(6);
    host_addr = 8'hA6; cyc(1);
    chk("rst_host_data_a6", {24'd0, host_data}, 32'd0);
    chk("rst_busy_after", {31'd0, busy}, 32'd0);
    oe_seen = 1'b0;
    scl = 1'b0; cyc(H);
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    chk("rst_ignore_bus_oe", {31'd0, oe_seen}, 32'd0);
    chk("rst_ignore_bus_busy", {31'd0, busy}, 32'd0);
    stop_c();

    cyc(4);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    chk("rd_queue_drained", rd_q.size(), 32'd0);
    chk("wr_pulse_count", wr_pulses, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
